msg_serializer: RTL and testbench

Parametrised message-to-byte serializer feeding the UART TX module. It captures an M-bit message on `start` and emits a runtime-selectable number of N-bit fragments, MSB- or LSB-first. Each fragment is sent with a one-cycle `enable` strobe, and the block then follows the TX `busy` handshake before presenting the next fragment. It replaces the fixed 16-byte sequencer: length, order, abort and completion reporting are added, and the message is latched so the source may change after `start`.

---
 rtl/msg_serializer.sv | 142 ++++++++++++++
 tb/tb_msg_serializer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_serializer.sv
// Message-to-fragment serializer for a UART TX: latches an M-bit message and
// hands it out N bits at a time, pacing each fragment on the TX busy handshake.
module msg_serializer #(
   parameter  int N  = 8,
   parameter  int M  = 128,
   localparam int K  = M / N,
   localparam int LW = $clog2(K) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [M-1:0]  data,
   input  logic [LW-1:0] length,
   input  logic          lsb_first,
   input  logic          abort,
   input  logic          busy,
   output logic          enable,
   output logic [N-1:0]  bus,
   output logic          active,
   output logic          done
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND      = 3'd1,
      WAIT_ACK  = 3'd2,
      WAIT_DONE = 3'd3,
      FINISH    = 3'd4
   } state_t;

   state_t        state_r, state_s;
   logic [M-1:0]  shreg_r, shreg_s;
   logic [LW-1:0] count_r, count_s;
   logic          order_r, order_s;
   logic          enable_r, enable_s;
   logic [N-1:0]  bus_r, bus_s;
   logic          active_r, active_s;
   logic          done_r, done_s;
   logic [N-1:0]  head_s;
   logic [LW-1:0] eff_len_s;

   // Fragment at the output end of the shift register and the clamped length.
   always_comb begin
      head_s    = order_r ? shreg_r[N-1:0] : shreg_r[M-1 -: N];
      eff_len_s = ((length == LW'(0)) || (length > LW'(K))) ? LW'(K) : length;
   end

   // Next-state and next-output logic; abort overrides every state.
   always_comb begin
      state_s  = state_r;
      shreg_s  = shreg_r;
      count_s  = count_r;
      order_s  = order_r;
      enable_s = 1'b0;
      bus_s    = bus_r;
      active_s = active_r;
      done_s   = 1'b0;
      if (abort) begin
         state_s  = IDLE;
         active_s = 1'b0;
         count_s  = LW'(0);
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  shreg_s  = data;
                  count_s  = eff_len_s;
                  order_s  = lsb_first;
                  active_s = 1'b1;
                  state_s  = SEND;
               end else begin
                  state_s  = IDLE;
               end
            end
            SEND: begin
               if (!busy) begin
                  enable_s = 1'b1;
                  bus_s    = head_s;
                  shreg_s  = order_r ? (shreg_r >> N) : (shreg_r << N);
                  state_s  = WAIT_ACK;
               end else begin
                  state_s  = SEND;
               end
            end
            WAIT_ACK: begin
               if (busy) begin
                  state_s = WAIT_DONE;
               end else begin
                  state_s = WAIT_ACK;
               end
            end
            WAIT_DONE: begin
               if (!busy) begin
                  count_s = count_r - LW'(1);
                  state_s = (count_r == LW'(1)) ? FINISH : SEND;
               end else begin
                  state_s = WAIT_DONE;
               end
            end
            FINISH: begin
               done_s   = 1'b1;
               active_s = 1'b0;
               state_s  = IDLE;
            end
            default: begin
               state_s  = IDLE;
               active_s = 1'b0;
               count_s  = LW'(0);
            end
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         shreg_r  <= '0;
         count_r  <= LW'(0);
         order_r  <= 1'b0;
         enable_r <= 1'b0;
         bus_r    <= '0;
         active_r <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         shreg_r  <= shreg_s;
         count_r  <= count_s;
         order_r  <= order_s;
         enable_r <= enable_s;
         bus_r    <= bus_s;
         active_r <= active_s;
         done_r   <= done_s;
      end
   end

   assign enable = enable_r;
   assign bus    = bus_r;
   assign active = active_r;
   assign done   = done_r;

endmodule

// File: tb/tb_msg_serializer.sv
// Randomized self-checking bench for msg_serializer with a behavioural TX model
// and a fragment-list reference model.
module tb_msg_serializer;
   localparam int N     = 8;
   localparam int M     = 128;
   localparam int K     = M / N;
   localparam int LW    = $clog2(K) + 1;
   localparam int TXLEN = 10;
   localparam logic [M-1:0] HELLO = 128'h48656C6C6F2C20576F726C6421212121;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [M-1:0]  data = '0;
   logic [LW-1:0] length = '0;
   logic          lsb_first = 1'b0;
   logic          abort = 1'b0;
   logic          busy;
   logic          enable;
   logic [N-1:0]  bus;
   logic          active;
   logic          done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int tx_cnt = 0;
   logic force_busy = 1'b0;
   logic [N-1:0] frag_q[$];
   int scyc_q[$];
   int done_cnt = 0;
   int wide_cnt = 0;
   int idle_strobe = 0;
   logic prev_en = 1'b0;

   msg_serializer #(.N(N), .M(M)) dut (
      .clk(clk), .reset(rst_n), .start(start), .data(data), .length(length),
      .lsb_first(lsb_first), .abort(abort), .busy(busy), .enable(enable),
      .bus(bus), .active(active), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // TX model: busy for TXLEN cycles after each strobe, plus a forced hold.
   assign busy = force_busy || (tx_cnt != 0);
   always @(negedge clk) begin
      if (enable) tx_cnt = TXLEN;
      else if (tx_cnt > 0) tx_cnt = tx_cnt - 1;
   end

   // Monitor: log every strobe and pulse.
   always @(negedge clk) begin
      if (enable) begin
         frag_q.push_back(bus);
         scyc_q.push_back(cyc);
         if (!active) idle_strobe++;
      end
      if (enable && prev_en) wide_cnt++;
      prev_en = enable;
      if (done) done_cnt++;
   end

   function automatic int eff_len(input int len);
      return (len == 0 || len > K) ? K : len;
   endfunction

   function automatic logic [N-1:0] exp_frag(input logic [M-1:0] d, input int i, input logic lsb);
      logic [M-1:0] t;
      t = lsb ? (d >> (i * N)) : (d >> (M - N - i * N));
      return t[N-1:0];
   endfunction

   function automatic logic [M-1:0] rand_msg();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic clear_log();
      frag_q.delete();
      scyc_q.delete();
      done_cnt = 0;
   endtask

   task automatic send_start(input logic [M-1:0] d, input int len, input logic lsb, output int c);
      @(negedge clk);
      c = cyc;
      data = d;
      length = LW'(len);
      lsb_first = lsb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (done_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_frags(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (frag_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", enable); end
      checks++; if (bus !== 8'h00) begin errors++; $display("FAIL reset_bus: got %h want 00", bus); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_hello();
      int c; bit ok;
      clear_log();
      send_start(HELLO, 0, 1'b0, c);
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL hello_active: got %b want 1", active); end
      wait_done(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL hello_timeout: done not seen"); end
      repeat (15) @(negedge clk);
      checks++; if (frag_q.size() !== 16) begin errors++; $display("FAIL hello_count: got %0d want 16", frag_q.size()); end
      for (int i = 0; i < 16 && i < frag_q.size(); i++) begin
         checks++;
         if (frag_q[i] !== exp_frag(HELLO, i, 1'b0)) begin
            errors++; $display("FAIL hello_frag%0d: got %h want %h", i, frag_q[i], exp_frag(HELLO, i, 1'b0));
         end
      end
      if (frag_q.size() > 0) begin
         checks++; if (frag_q[0] !== 8'h48) begin errors++; $display("FAIL hello_first: got %h want 48", frag_q[0]); end
         checks++; if (scyc_q[0] !== c + 2) begin errors++; $display("FAIL hello_latency: got %0d want %0d", scyc_q[0], c + 2); end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL hello_done: got %0d want 1", done_cnt); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL hello_idle: got %b want 0", active); end
   endtask

   task automatic test_len3_lsb();
      int c; bit ok;
      clear_log();
      send_start(HELLO, 3, 1'b1, c);
      wait_done(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL len3_timeout: done not seen"); end
      repeat (30) @(negedge clk);
      checks++; if (frag_q.size() !== 3) begin errors++; $display("FAIL len3_count: got %0d want 3", frag_q.size()); end
      for (int i = 0; i < 3 && i < frag_q.size(); i++) begin
         checks++;
         if (frag_q[i] !== 8'h21) begin errors++; $display("FAIL len3_frag%0d: got %h want 21", i, frag_q[i]); end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL len3_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_random();
      int c, len; bit ok; logic lsb; logic [M-1:0] d;
      for (int n = 0; n < 6; n++) begin
         clear_log();
         d = rand_msg();
         len = $urandom_range(0, 31);
         lsb = 1'($urandom_range(0, 1));
         send_start(d, len, lsb, c);
         wait_done(1, ok);
         repeat (3) @(negedge clk);
         checks++;
         if (!ok || frag_q.size() !== eff_len(len)) begin
            errors++; $display("FAIL rand%0d_count: got %0d want %0d (len %0d)", n, frag_q.size(), eff_len(len), len);
         end
         for (int i = 0; i < eff_len(len) && i < frag_q.size(); i++) begin
            checks++;
            if (frag_q[i] !== exp_frag(d, i, lsb)) begin
               errors++; $display("FAIL rand%0d_frag%0d: got %h want %h", n, i, frag_q[i], exp_frag(d, i, lsb));
            end
         end
      end
   endtask

   task automatic test_busy_hold();
      int c, c2; bit ok;
      clear_log();
      @(negedge clk);
      force_busy = 1'b1;
      send_start(HELLO, 4, 1'b0, c);
      data = '0;
      repeat (19) @(negedge clk);
      checks++; if (frag_q.size() !== 0) begin errors++; $display("FAIL hold_nostrobe: got %0d strobes want 0", frag_q.size()); end
      c2 = cyc;
      force_busy = 1'b0;
      wait_done(1, ok);
      checks++; if (!ok || frag_q.size() !== 4) begin errors++; $display("FAIL hold_count: got %0d want 4", frag_q.size()); end
      if (scyc_q.size() > 0) begin
         checks++; if (scyc_q[0] !== c2 + 1) begin errors++; $display("FAIL hold_first: got %0d want %0d", scyc_q[0], c2 + 1); end
      end
      for (int i = 0; i < 4 && i < frag_q.size(); i++) begin
         checks++;
         if (frag_q[i] !== exp_frag(HELLO, i, 1'b0)) begin
            errors++; $display("FAIL hold_frag%0d: got %h want %h", i, frag_q[i], exp_frag(HELLO, i, 1'b0));
         end
      end
   endtask

   task automatic test_abort();
      int c; bit ok; logic [M-1:0] d;
      clear_log();
      send_start(HELLO, 16, 1'b0, c);
      wait_frags(3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL abort_reach: got %0d strobes want 3", frag_q.size()); end
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL abort_active: got %b want 0", active); end
      repeat (60) @(negedge clk);
      checks++; if (frag_q.size() !== 3) begin errors++; $display("FAIL abort_count: got %0d want 3", frag_q.size()); end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
      clear_log();
      d = rand_msg();
      send_start(d, 16, 1'b0, c);
      wait_done(1, ok);
      checks++; if (!ok || frag_q.size() !== 16) begin errors++; $display("FAIL abort_fresh_count: got %0d want 16", frag_q.size()); end
      for (int i = 0; i < 16 && i < frag_q.size(); i++) begin
         checks++;
         if (frag_q[i] !== exp_frag(d, i, 1'b0)) begin
            errors++; $display("FAIL abort_fresh_frag%0d: got %h want %h", i, frag_q[i], exp_frag(d, i, 1'b0));
         end
      end
   endtask

   task automatic test_async_reset();
      int c; bit ok; logic [M-1:0] d; logic lsb;
      clear_log();
      send_start(HELLO, 0, 1'b1, c);
      wait_frags(6, ok);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (enable !== 1'b0) begin errors++; $display("FAIL arst_enable: got %b want 0", enable); end
      checks++; if (bus !== 8'h00) begin errors++; $display("FAIL arst_bus: got %h want 00", bus); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL arst_active: got %b want 0", active); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", done); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      checks++; if (!ok || frag_q.size() !== 6 || done_cnt !== 0) begin
         errors++; $display("FAIL arst_stop: got %0d strobes %0d done want 6 and 0", frag_q.size(), done_cnt);
      end
      clear_log();
      d = rand_msg();
      lsb = 1'($urandom_range(0, 1));
      send_start(d, 5, lsb, c);
      wait_done(1, ok);
      checks++; if (!ok || frag_q.size() !== 5) begin errors++; $display("FAIL arst_restart_count: got %0d want 5", frag_q.size()); end
      for (int i = 0; i < 5 && i < frag_q.size(); i++) begin
         checks++;
         if (frag_q[i] !== exp_frag(d, i, lsb)) begin
            errors++; $display("FAIL arst_restart_frag%0d: got %h want %h", i, frag_q[i], exp_frag(d, i, lsb));
         end
      end
   endtask

   task automatic test_ignored();
      int c; bit ok; logic [M-1:0] d1, d2;
      clear_log();
      d1 = rand_msg();
      d2 = ~d1;
      send_start(d1, 4, 1'b0, c);
      wait_frags(1, ok);
      @(negedge clk);
      data = d2; length = LW'(2); lsb_first = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1, ok);
      repeat (40) @(negedge clk);
      checks++; if (!ok || frag_q.size() !== 4) begin errors++; $display("FAIL ign_count: got %0d want 4", frag_q.size()); end
      for (int i = 0; i < 4 && i < frag_q.size(); i++) begin
         checks++;
         if (frag_q[i] !== exp_frag(d1, i, 1'b0)) begin
            errors++; $display("FAIL ign_frag%0d: got %h want %h", i, frag_q[i], exp_frag(d1, i, 1'b0));
         end
      end
      @(negedge clk);
      data = d2; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (frag_q.size() !== 4) begin errors++; $display("FAIL ign_abort_start: got %0d strobes want 4", frag_q.size()); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL ign_active: got %b want 0", active); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done: got %0d want 1", done_cnt); end
      checks++; if (bus !== exp_frag(d1, 3, 1'b0)) begin errors++; $display("FAIL ign_bus_hold: got %h want %h", bus, exp_frag(d1, 3, 1'b0)); end
   endtask

   task automatic test_back_to_back();
      int c, c2, n; bit ok; logic [M-1:0] d1, d2;
      clear_log();
      d1 = rand_msg();
      d2 = rand_msg();
      send_start(d1, 2, 1'b0, c);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin ok = 1'b1; break; end
      end
      c2 = cyc;
      data = d2; length = LW'(3); lsb_first = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2, ok);
      repeat (3) @(negedge clk);
      n = frag_q.size();
      checks++; if (!ok || n !== 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", n); end
      if (n == 5) begin
         checks++; if (scyc_q[2] !== c2 + 2) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", scyc_q[2], c2 + 2); end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (frag_q[2 + i] !== exp_frag(d2, i, 1'b1)) begin
               errors++; $display("FAIL b2b_frag%0d: got %h want %h", i, frag_q[2 + i], exp_frag(d2, i, 1'b1));
            end
         end
      end
   endtask

   task automatic test_protocol();
      checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL enable_width: got %0d wide strobes want 0", wide_cnt); end
      checks++; if (idle_strobe !== 0) begin errors++; $display("FAIL strobe_inactive: got %0d want 0", idle_strobe); end
   endtask

   initial begin
      test_reset();
      test_hello();
      test_len3_lsb();
      test_random();
      test_busy_hold();
      test_abort();
      test_async_reset();
      test_ignored();
      test_back_to_back();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
